prbs31_checker: RTL
===================

Name: prbs31_checker

Overview:
- Receive-side companion to the team's PRBS31 pattern generator (x^31 + x^28 + 1, serial MSB-out stream).
- Self-synchronises to an incoming 1-bit PRBS31 stream and declares lock.
- Once locked, free-runs its own local LFSR and counts bit errors and checked bits.
- Sits at the loopback/receive pin of the test chip; status and counters feed the output mux.

Parameters:
- LOCK_CNT, 64: consecutive correct predictions required to go from SYNC to LOCKED.
- WIN, 256: length of the error-rate window, in valid bits, used while LOCKED.
- UNLOCK_ERRS, 8: errors within one window that force loss of lock.
- CNT_W, 16: width of err_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Asynchronous, active-high: asserted when 1, despite the name.
- din  in  1  received serial bit.
- din_valid  in  1  din is sampled on a rising clk edge only when this is 1.
- clr_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  1 while in LOCKED.
- err_pulse  out  1  one-cycle pulse per errored bit while LOCKED.
- err_count  out  CNT_W  saturating error count.
- bit_count  out  32  saturating count of bits checked while LOCKED.

Behaviour:
- Reset (rst_n=1, asynchronous): state=HUNT; sr=0; fill/match/window counters=0; locked=0; err_pulse=0; err_count=0; bit_count=0.
- sr[30:0] is the local history register. A bit b is shifted in as sr <= {sr[29:0], b}, so sr[0] is the newest bit.
- Prediction: pred = sr[27] ^ sr[30]. These are the same taps as the generator. Stream recurrence: y(m) = y(m-28) ^ y(m-31).
- Only cycles with din_valid=1 advance any state, shift register or counter. With din_valid=0, everything holds and err_pulse=0.
- HUNT:
  - Shift din into sr and increment fill.
  - After 31 valid bits (fill==31) with sr != 0, go to SYNC and set match=0.
  - If sr==0 at fill==31, keep hunting (fill stays 31). An all-zero input must never lock.
- SYNC:
  - Shift din into sr and compare din to pred.
  - Match: match++. When match reaches LOCK_CNT, go to LOCKED and clear the window counters.
  - Mismatch: go to HUNT with fill=31 and keep the shifted sr, so a resync can start on the next bit.
- LOCKED:
  - sr self-advances with pred, not din, so an error does not propagate into later predictions.
  - err = din ^ pred.
  - bit_count++ every valid bit, saturating at 2^32-1.
  - On err: err_pulse=1 on the cycle after the sampling edge (registered); err_count++, saturating at 2^CNT_W-1; errwin++.
  - wincnt counts valid bits 0..WIN-1 and wraps. An error on the last bit of a window is counted in that window, then errwin clears on the wrap.
  - When errwin reaches UNLOCK_ERRS: go to HUNT with fill=0 and sr=0, and deassert locked on the same edge. Counters are not cleared.
- Output timing: locked is registered and reflects the state after each edge.
  - Rises on the edge that samples the LOCK_CNT-th matching bit.
  - Falls on the edge that samples the UNLOCK_ERRS-th error in a window.
- clr_cnt=1 zeros err_count and bit_count. It has priority over a coincident increment, which is dropped. It does not affect state, lock or window counters.
- Reset mid-operation: immediate return to reset values regardless of state. Hunting restarts after rst_n deasserts.

Test Plan:
- Reset: hold rst_n=1 with random din/din_valid -> locked=0, err_pulse=0, err_count=0, bit_count=0 throughout. Assert rst_n asynchronously mid-cycle -> outputs clear before the next edge.
- Clean lock: feed the generator stream from its reset seed 31'd1 (30 zeros, then 1, ...) with din_valid=1 -> locked rises on the edge of valid bit 95 (31+64). err_count stays 0. After 1000 further bits, bit_count=1000.
- Single error: while locked, invert 1 bit -> exactly one err_pulse, err_count=1, locked stays 1, no follow-on errors.
- Loss of lock: invert 8 bits within one 256-bit window -> locked falls at the 8th error, err_count=8. Continue the clean stream -> relock exactly 95 valid bits later.
- Window boundary: 7 errors in window N plus 1 error in the first bit of window N+1 -> locked stays 1, err_count=8.
- Corner cases:
  - Constant din=0 for 500 bits -> never locks.
  - din_valid toggling 1-of-3 on a clean stream -> lock after 95 valid bits.
  - clr_cnt coincident with an errored bit -> err_count=0 and err_pulse still asserts.

Source files
------------

// File: rtl/prbs31_checker_if.sv
// Bus between a serial PRBS31 receive pin and its checker.
// The master drives the received bits; the slave reports lock status and counters.
interface prbs31_checker_if #(
   parameter int CNT_W = 16
);
   logic             din;
   logic             din_valid;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [31:0]      bit_count;

   modport master (
      output din, din_valid, clr_cnt,
      input  locked, err_pulse, err_count, bit_count
   );

   modport slave (
      input  din, din_valid, clr_cnt,
      output locked, err_pulse, err_count, bit_count
   );
endinterface

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronises to the serial stream,
// then free-runs a local LFSR and counts bit errors and checked bits.
module prbs31_checker #(
   parameter int LOCK_CNT    = 64,
   parameter int WIN         = 256,
   parameter int UNLOCK_ERRS = 8,
   parameter int CNT_W       = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   prbs31_checker_if.slave bus
);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int EW_W    = $clog2(UNLOCK_ERRS + 1);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t             state_q, state_d;
   logic [30:0]        sr_q, sr_d;
   logic [4:0]         fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [WIN_W-1:0]   wincnt_q, wincnt_d;
   logic [EW_W-1:0]    errwin_q, errwin_d;
   logic               locked_q, locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0]   err_count_q, err_count_d;
   logic [31:0]        bit_count_q, bit_count_d;

   logic               pred;
   logic               err;
   logic [EW_W-1:0]    errwin_inc;
   logic               win_last;

   assign pred       = sr_q[27] ^ sr_q[30];
   assign err        = bus.din ^ pred;
   assign errwin_inc = errwin_q + EW_W'(err);
   assign win_last   = (wincnt_q == WIN_W'(WIN - 1));

   // Reset here is asynchronous and active-high even though the port is named rst_n.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= HUNT;
         sr_q        <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         wincnt_q    <= '0;
         errwin_q    <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
         bit_count_q <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         wincnt_q    <= wincnt_d;
         errwin_q    <= errwin_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
         bit_count_q <= bit_count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      fill_d   = fill_q;
      match_d  = match_q;
      wincnt_d = wincnt_q;
      errwin_d = errwin_q;
      if (bus.din_valid) begin
         case (state_q)
            HUNT: begin
               sr_d = {sr_q[29:0], bus.din};
               if (fill_q != 5'd31) fill_d = fill_q + 5'd1;
               // An all-zero history is the LFSR lock-up state and must never be trusted.
               if (fill_d == 5'd31 && sr_d != '0) begin
                  state_d = SYNC;
                  match_d = '0;
               end
            end
            SYNC: begin
               sr_d = {sr_q[29:0], bus.din};
               if (err) begin
                  state_d = HUNT;
                  fill_d  = 5'd31;
               end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                  state_d  = LOCKED;
                  wincnt_d = '0;
                  errwin_d = '0;
               end else begin
                  match_d = match_q + MATCH_W'(1);
               end
            end
            LOCKED: begin
               // Self-advance on the prediction so a line error never corrupts later predictions.
               sr_d     = {sr_q[29:0], pred};
               wincnt_d = win_last ? '0 : wincnt_q + WIN_W'(1);
               if (errwin_inc == EW_W'(UNLOCK_ERRS)) begin
                  state_d  = HUNT;
                  fill_d   = '0;
                  sr_d     = '0;
                  errwin_d = '0;
               end else if (win_last) begin
                  errwin_d = '0;
               end else begin
                  errwin_d = errwin_inc;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      locked_d    = (state_d == LOCKED);
      err_pulse_d = bus.din_valid && (state_q == LOCKED) && err;
      err_count_d = err_count_q;
      bit_count_d = bit_count_q;
      if (bus.clr_cnt) begin
         err_count_d = '0;
         bit_count_d = '0;
      end else if (bus.din_valid && state_q == LOCKED) begin
         if (bit_count_q != '1) bit_count_d = bit_count_q + 32'd1;
         if (err && err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count_q;
   assign bus.bit_count = bit_count_q;
endmodule
